pll_drp_phase_sequencer: RTL and testbench
==========================================

// Module: pll_drp_phase_sequencer
// PURPOSE
//  Runtime phase-shift controller for a 7-series PLLE2_ADV via its DRP port.
//  - Accepts one request: output index, PHASE_MUX, DELAY_TIME.
//  - Performs a read-modify-write of that output's two CLKOUT registers.
//  - Replaces manual VIO-driven phase tuning of the FMC capture/launch clocks.
//  - Runs entirely in the DRP clock domain (the management clock).
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles allowed from drp_en pulse to drp_rdy before abort; legal range 2..65535
//  LOCK_CYCLES     4096  cycles allowed for pll_lock to reassert (PLL_DRP_RST_EN build only)
// PORTS
//  clk          in   1   DRP/management clock
//  rst          in   1   asynchronous active-high reset
//  cfg_en       in   1   request strobe; sampled only in IDLE
//  cfg_outsel   in   3   CLKOUT index, 0..5
//  cfg_mux      in   3   new PHASE_MUX value (reg1[15:13])
//  cfg_delay    in   6   new DELAY_TIME value (reg2[5:0])
//  cfg_busy     out  1   high from accept until the done pulse
//  cfg_done     out  1   one-cycle completion pulse
//  cfg_err      out  1   valid with cfg_done; 1 = bad index, DRP timeout or lock timeout
//  drp_en       out  1   DRP strobe, one-cycle pulse
//  drp_we       out  1   DRP write enable
//  drp_addr     out  7   DRP address
//  drp_di       out  16  DRP write data
//  drp_do       in   16  DRP read data
//  drp_rdy      in   1   DRP ready
//  pll_lock     in   1   PLL LOCKED
//  pll_rst      out  1   PLL reset request (PLL_DRP_RST_EN build only; otherwise tied 0)
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; captured fields and counters 0.
//  Reg1 address map, by cfg_outsel 0..5: 0x08, 0x0A, 0x0C, 0x0E, 0x10, 0x06. Reg2 = reg1 + 1.
//  IDLE
//   - On cfg_en: capture cfg_outsel, cfg_mux and cfg_delay; set cfg_busy.
//   - cfg_outsel 6 or 7: go to DONE with err=1; no DRP access is issued.
//   - Otherwise go to RD1.
//   - cfg_en while busy is ignored and is not queued.
//  Access rule (every DRP access)
//   - Pulse drp_en for 1 cycle on state entry.
//   - drp_addr, drp_we and drp_di are stable from that cycle until drp_rdy.
//   - Wait for drp_rdy; the timeout counter restarts on each access.
//   - No drp_rdy within TIMEOUT_CYCLES cycles after the pulse: go to DONE with err=1.
//  Sequence
//   - RD1: read reg1; on drp_rdy latch drp_do.
//   - WR1: write {cfg_mux, rd[12:0]} to reg1.
//   - RD2: read reg2; on drp_rdy latch drp_do.
//   - WR2: write {rd[15:6], cfg_delay} to reg2.
//   - Then LOCK (PLL_DRP_RST_EN build) or DONE.
//  DONE: one cycle; cfg_done=1, cfg_err valid, cfg_busy drops the same cycle; next state IDLE.
//  Unexpected drp_rdy outside a wait (IDLE, DONE, LOCK): ignored.
//  Latency, with drp_rdy 1 cycle after each drp_en: cfg_en -> cfg_done = 10 cycles.
//  Reset mid-sequence: all outputs drop asynchronously to 0; the partial PLL write is not rolled back.
//  drp_do is sampled only on the drp_rdy cycle of a read.
// CONFIGURATION
//  `PLL_DRP_RST_EN defined
//   - pll_rst asserts on RD1 entry and stays high through WR2 completion.
//   - After WR2 it releases, then the block waits in LOCK for pll_lock=1.
//   - pll_lock=1 within LOCK_CYCLES: DONE with err=0; otherwise DONE with err=1.
//  `PLL_DRP_RST_EN undefined
//   - pll_rst is constant 0; LOCK state is absent; pll_lock is unused.
//   - Phase change is applied live, with no relock.
// TESTING
//  1. outsel=0, mux=5, delay=0x12; model: reg 0x08=0x1234, 0x09=0xABC0
//     -> writes 0xB234 to 0x08 and 0xABD2 to 0x09; done after 10 cycles; err=0.
//  2. outsel=5 -> addresses 0x06 then 0x07.
//     outsel=6 -> done 2 cycles after cfg_en, err=1, zero drp_en pulses.
//  3. Model never asserts drp_rdy on the RD2 read, TIMEOUT_CYCLES=64
//     -> done with err=1 exactly 64 cycles after the RD2 drp_en; no WR2 issued.
//  4. Second cfg_en pulsed during RD1 of a first request -> only one 4-access sequence runs.
//     A new cfg_en the cycle after done is accepted.
//  5. rst pulsed during WR1 -> all outputs 0 in the same cycle; state IDLE; a new request completes normally.
//  6. PLL_DRP_RST_EN build: pll_lock held low 100 cycles after WR2 -> pll_rst high RD1..WR2, done err=0.
//     pll_lock never rises -> err=1 after LOCK_CYCLES.

Source files
------------

// File: rtl/pll_drp_phase_sequencer.sv
// Purpose: read-modify-write of one PLLE2_ADV CLKOUT phase (PHASE_MUX, DELAY_TIME) through the DRP port.
// Latency: cfg_en to cfg_done rise is 10 cycles when drp_rdy follows each drp_en by one cycle.
// Backpressure: cfg_busy is high while a request is in flight; cfg_en seen while busy is dropped, not queued.
// Build option: define PLL_DRP_RST_EN to hold the PLL in reset across the writes and then wait for relock.
module pll_drp_phase_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,   // drp_en to drp_rdy allowance, 2..65535
    parameter int unsigned LOCK_CYCLES    = 4096  // relock allowance, PLL_DRP_RST_EN build only
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_en,
    input  logic [2:0]  cfg_outsel,
    input  logic [2:0]  cfg_mux,
    input  logic [5:0]  cfg_delay,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        drp_en,
    output logic        drp_we,
    output logic [6:0]  drp_addr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_rdy,
    input  logic        pll_lock,
    output logic        pll_rst
);

    // The timeout fires on the edge where the counter reaches this value, so that
    // cfg_done rises exactly TIMEOUT_CYCLES cycles after the unanswered drp_en rose.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        WR1,
        RD2,
        WR2,
`ifdef PLL_DRP_RST_EN
        LOCK,
`endif
        DONE
    } state_t;

    state_t      state_q;
    logic [6:0]  addr1_q;   // CLKOUTn reg1 address; reg2 sits at addr1_q + 1
    logic [2:0]  mux_q;
    logic [5:0]  delay_q;
    logic        err_q;     // outcome reported on the cfg_done cycle
    logic [31:0] cnt_q;     // shared DRP-timeout / relock counter, cleared on every access

    // CLKOUT0..5 reg1 addresses; CLKOUT5 breaks the stride and lives below CLKOUT0.
    function automatic logic [6:0] reg1_addr(input logic [2:0] sel);
        logic [6:0] a;
        case (sel)
            3'd0:    a = 7'h08;
            3'd1:    a = 7'h0A;
            3'd2:    a = 7'h0C;
            3'd3:    a = 7'h0E;
            3'd4:    a = 7'h10;
            3'd5:    a = 7'h06;
            default: a = 7'h00;
        endcase
        return a;
    endfunction

`ifdef PLL_DRP_RST_EN
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);
`else
    // Live phase change: the PLL is never reset, so lock status is irrelevant here.
    logic unused_lock;
    assign unused_lock = pll_lock ^ (LOCK_CYCLES == 0);
    assign pll_rst     = 1'b0;
`endif

    // Request sequencing, DRP handshakes and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr1_q  <= '0;
            mux_q    <= '0;
            delay_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            drp_en   <= 1'b0;
            drp_we   <= 1'b0;
            drp_addr <= '0;
            drp_di   <= '0;
`ifdef PLL_DRP_RST_EN
            pll_rst  <= 1'b0;
`endif
        end else begin
            // drp_en is a single-cycle strobe issued only on entry to an access state
            drp_en <= 1'b0;
            case (state_q)
                IDLE: begin
                    cfg_done <= 1'b0;
                    cfg_err  <= 1'b0;
                    if (cfg_en) begin
                        addr1_q  <= reg1_addr(cfg_outsel);
                        mux_q    <= cfg_mux;
                        delay_q  <= cfg_delay;
                        cnt_q    <= '0;
                        cfg_busy <= 1'b1;
                        if (cfg_outsel > 3'd5) begin
                            // No such CLKOUT: report failure without touching the DRP
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q    <= 1'b0;
                            drp_en   <= 1'b1;
                            drp_we   <= 1'b0;
                            drp_addr <= reg1_addr(cfg_outsel);
                            drp_di   <= '0;
`ifdef PLL_DRP_RST_EN
                            pll_rst  <= 1'b1;
`endif
                            state_q  <= RD1;
                        end
                    end
                end

                RD1, WR1, RD2, WR2: begin
                    if (drp_rdy) begin
                        cnt_q <= '0;
                        case (state_q)
                            RD1: begin
                                // Replace PHASE_MUX, keep the rest of reg1 as read
                                drp_en  <= 1'b1;
                                drp_we  <= 1'b1;
                                drp_di  <= {mux_q, drp_do[12:0]};
                                state_q <= WR1;
                            end
                            WR1: begin
                                drp_en   <= 1'b1;
                                drp_we   <= 1'b0;
                                drp_addr <= addr1_q + 7'd1;
                                drp_di   <= '0;
                                state_q  <= RD2;
                            end
                            RD2: begin
                                // Replace DELAY_TIME, keep the rest of reg2 as read
                                drp_en  <= 1'b1;
                                drp_we  <= 1'b1;
                                drp_di  <= {drp_do[15:6], delay_q};
                                state_q <= WR2;
                            end
                            default: begin
                                drp_we   <= 1'b0;
                                drp_addr <= '0;
                                drp_di   <= '0;
`ifdef PLL_DRP_RST_EN
                                pll_rst  <= 1'b0;
                                state_q  <= LOCK;
`else
                                state_q  <= DONE;
`endif
                            end
                        endcase
                    end else if (cnt_q == TO_LAST) begin
                        // DRP never answered; a partial write stays in the PLL
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

`ifdef PLL_DRP_RST_EN
                LOCK: begin
                    if (pll_lock) begin
                        state_q <= DONE;
                    end else if (cnt_q == LOCK_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
`endif

                DONE: begin
                    cfg_done <= 1'b1;
                    cfg_err  <= err_q;
                    cfg_busy <= 1'b0;
                    drp_we   <= 1'b0;
                    drp_addr <= '0;
                    drp_di   <= '0;
                    cnt_q    <= '0;
`ifdef PLL_DRP_RST_EN
                    pll_rst  <= 1'b0;
`endif
                    state_q  <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_phase_sequencer.sv
`timescale 1ns/1ps
module tb_pll_drp_phase_sequencer;

    localparam int TO = 64;
    localparam int LK = 4096;
`ifdef PLL_DRP_RST_EN
    localparam int   EXTRA    = 1;     // one LOCK cycle with pll_lock already high
    localparam logic EXP_PRST = 1'b1;
`else
    localparam int   EXTRA    = 0;
    localparam logic EXP_PRST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_en = 1'b0;
    logic [2:0]  cfg_outsel = '0;
    logic [2:0]  cfg_mux = '0;
    logic [5:0]  cfg_delay = '0;
    logic        cfg_busy, cfg_done, cfg_err;
    logic        drp_en, drp_we;
    logic [6:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_rdy = 1'b0;
    logic        pll_lock = 1'b1;
    logic        pll_rst;

    pll_drp_phase_sequencer #(.TIMEOUT_CYCLES(TO), .LOCK_CYCLES(LK)) dut (
        .clk(clk), .rst(rst),
        .cfg_en(cfg_en), .cfg_outsel(cfg_outsel), .cfg_mux(cfg_mux), .cfg_delay(cfg_delay),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_rdy(drp_rdy), .pll_lock(pll_lock), .pll_rst(pll_rst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- PLL DRP register model ----------------
    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
        int          cyc;
        logic        prst;
    } acc_t;

    logic [15:0] mem [128];
    acc_t        acc_q[$];
    int          drop_at = -1;   // index of the access (per request) left unanswered
    bit          rand_lat = 1'b0;
    bit          pend = 1'b0;
    int          cd = 0;
    logic        pwe;
    logic [6:0]  paddr;
    logic [15:0] pdi;
    int          stab_viol = 0;
    int          c0 = 0;

    logic [6:0] base_tab [6] = '{7'h08, 7'h0A, 7'h0C, 7'h0E, 7'h10, 7'h06};

    // Answers each drp_en after 1..3 cycles, junk on drp_do otherwise
    always @(negedge clk) begin
        drp_rdy = 1'b0;
        drp_do  = 16'($urandom);
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (drp_we !== pwe || drp_addr !== paddr || drp_di !== pdi) stab_viol++;
                if (cd == 0) begin
                    drp_rdy = 1'b1;
                    if (pwe) mem[paddr] = pdi;
                    else     drp_do = mem[paddr];
                    pend = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (drp_en === 1'b1) begin
                acc_q.push_back('{we: drp_we, addr: drp_addr, di: drp_di, cyc: cyc, prst: pll_rst});
                if (drop_at != acc_q.size() - 1) begin
                    pend  = 1'b1;
                    pwe   = drp_we;
                    paddr = drp_addr;
                    pdi   = drp_di;
                    cd    = rand_lat ? int'($urandom_range(2, 0)) : 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] sel, input logic [2:0] mux, input logic [5:0] dly);
        @(posedge clk); #1;
        acc_q.delete();
        c0 = cyc;
        cfg_outsel = sel;
        cfg_mux    = mux;
        cfg_delay  = dly;
        cfg_en     = 1'b1;
        @(posedge clk); #1;
        cfg_en = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int dcyc, output logic derr);
        ok = 1'b0; dcyc = 0; derr = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) begin
                ok = 1'b1; dcyc = cyc; derr = cfg_err;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({cfg_busy, cfg_done, cfg_err, drp_en, drp_we, pll_rst} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {cfg_busy, cfg_done, cfg_err, drp_en, drp_we, pll_rst}); end
        checks++; if (drp_addr !== 7'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", drp_addr); end
        checks++; if (drp_di !== 16'h0000) begin errors++; $display("FAIL reset_di got %h exp 0000", drp_di); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        bit ok; int dc; logic de;
        rand_lat = 1'b0; drop_at = -1;
        mem[7'h08] = 16'h1234; mem[7'h09] = 16'hABC0;
        issue(3'd0, 3'd5, 6'h12);
        wait_done(100, ok, dc, de);
        checks++; if (!ok) begin errors++; $display("FAIL dir_done got none exp done"); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL dir_err got %b exp 0", de); end
        checks++; if (dc - c0 != 10 + EXTRA) begin errors++; $display("FAIL dir_latency got %0d exp %0d", dc - c0, 10 + EXTRA); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL dir_busy_at_done got %b exp 0", cfg_busy); end
        checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL dir_count got %0d exp 4", acc_q.size()); end
        if (acc_q.size() == 4) begin
            checks++; if ({acc_q[0].we, acc_q[0].addr} !== {1'b0, 7'h08}) begin errors++; $display("FAIL dir_rd1 got %b/%h exp 0/08", acc_q[0].we, acc_q[0].addr); end
            checks++; if ({acc_q[1].we, acc_q[1].addr, acc_q[1].di} !== {1'b1, 7'h08, 16'hB234}) begin
                errors++; $display("FAIL dir_wr1 got %b/%h/%h exp 1/08/b234", acc_q[1].we, acc_q[1].addr, acc_q[1].di); end
            checks++; if ({acc_q[2].we, acc_q[2].addr} !== {1'b0, 7'h09}) begin errors++; $display("FAIL dir_rd2 got %b/%h exp 0/09", acc_q[2].we, acc_q[2].addr); end
            checks++; if ({acc_q[3].we, acc_q[3].addr, acc_q[3].di} !== {1'b1, 7'h09, 16'hABD2}) begin
                errors++; $display("FAIL dir_wr2 got %b/%h/%h exp 1/09/abd2", acc_q[3].we, acc_q[3].addr, acc_q[3].di); end
        end
        @(negedge clk);
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL dir_done_pulse got %b exp 0", cfg_done); end
    endtask

    task automatic test_outsel_range();
        bit ok; int dc; logic de;
        rand_lat = 1'b0; drop_at = -1;
        issue(3'd5, 3'd1, 6'h3F);
        wait_done(100, ok, dc, de);
        checks++; if (!ok || de !== 1'b0) begin errors++; $display("FAIL sel5_err got ok=%0b err=%b exp ok=1 err=0", ok, de); end
        checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL sel5_count got %0d exp 4", acc_q.size()); end
        else begin
            checks++; if ({acc_q[0].addr, acc_q[1].addr, acc_q[2].addr, acc_q[3].addr} !== {7'h06, 7'h06, 7'h07, 7'h07}) begin
                errors++; $display("FAIL sel5_addr got %h %h %h %h exp 06 06 07 07", acc_q[0].addr, acc_q[1].addr, acc_q[2].addr, acc_q[3].addr); end
        end
        for (int s = 6; s <= 7; s++) begin
            issue(3'(s), 3'd2, 6'h01);
            wait_done(20, ok, dc, de);
            checks++; if (!ok || de !== 1'b1) begin errors++; $display("FAIL bad_sel%0d_err got ok=%0b err=%b exp ok=1 err=1", s, ok, de); end
            checks++; if (dc - c0 != 2) begin errors++; $display("FAIL bad_sel%0d_latency got %0d exp 2", s, dc - c0); end
            checks++; if (acc_q.size() != 0) begin errors++; $display("FAIL bad_sel%0d_drp got %0d exp 0", s, acc_q.size()); end
        end
    endtask

    task automatic test_timeout();
        bit ok; int dc; logic de;
        rand_lat = 1'b0; drop_at = 2;
        mem[7'h0E] = 16'($urandom); mem[7'h0F] = 16'($urandom);
        issue(3'd3, 3'd7, 6'h2A);
        wait_done(200, ok, dc, de);
        checks++; if (!ok || de !== 1'b1) begin errors++; $display("FAIL to_err got ok=%0b err=%b exp ok=1 err=1", ok, de); end
        checks++; if (acc_q.size() != 3) begin errors++; $display("FAIL to_count got %0d exp 3", acc_q.size()); end
        else begin
            checks++; if (dc - acc_q[2].cyc != TO) begin errors++; $display("FAIL to_latency got %0d exp %0d", dc - acc_q[2].cyc, TO); end
        end
        drop_at = -1;
    endtask

    task automatic test_back_to_back();
        bit ok; int dc; logic de;
        rand_lat = 1'b0; drop_at = -1;
        issue(3'd1, 3'd3, 6'h05);
        @(posedge clk); #1;
        cfg_outsel = 3'd3; cfg_en = 1'b1;
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", cfg_busy); end
        @(posedge clk); #1;
        cfg_en = 1'b0;
        wait_done(100, ok, dc, de);
        checks++; if (!ok || acc_q.size() != 4) begin errors++; $display("FAIL b2b_single got ok=%0b n=%0d exp ok=1 n=4", ok, acc_q.size()); end
        else begin
            checks++; if ({acc_q[0].addr, acc_q[3].addr} !== {7'h0A, 7'h0B}) begin
                errors++; $display("FAIL b2b_first_addr got %h %h exp 0a 0b", acc_q[0].addr, acc_q[3].addr); end
        end
        // new request raised during the done cycle, sampled on the first IDLE edge
        acc_q.delete();
        c0 = cyc;
        cfg_outsel = 3'd2; cfg_mux = 3'd6; cfg_delay = 6'h11; cfg_en = 1'b1;
        @(posedge clk); #1;
        cfg_en = 1'b0;
        wait_done(100, ok, dc, de);
        checks++; if (!ok || de !== 1'b0) begin errors++; $display("FAIL b2b_next got ok=%0b err=%b exp ok=1 err=0", ok, de); end
        checks++; if (dc - c0 != 10 + EXTRA) begin errors++; $display("FAIL b2b_next_latency got %0d exp %0d", dc - c0, 10 + EXTRA); end
        checks++; if (acc_q.size() != 4 || acc_q[0].addr !== 7'h0C) begin
            errors++; $display("FAIL b2b_next_addr got n=%0d exp n=4 addr 0c", acc_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok; int dc; logic de;
        logic [15:0] r1, r2;
        rand_lat = 1'b0; drop_at = -1;
        issue(3'd4, 3'd1, 6'h09);
        for (int i = 0; i < 20 && acc_q.size() < 2; i++) begin
            @(negedge clk); #2;
        end
        checks++; if (acc_q.size() != 2 || cfg_busy !== 1'b1) begin errors++; $display("FAIL rstmid_reach_wr1 got n=%0d exp 2", acc_q.size()); end
        rst = 1'b1;
        pend = 1'b0;
        #1;
        checks++; if ({cfg_busy, cfg_done, cfg_err, drp_en, drp_we, pll_rst} !== 6'b0) begin
            errors++; $display("FAIL rstmid_flags got %b exp 000000", {cfg_busy, cfg_done, cfg_err, drp_en, drp_we, pll_rst}); end
        checks++; if ({drp_addr, drp_di} !== 23'h0) begin errors++; $display("FAIL rstmid_bus got %h/%h exp 00/0000", drp_addr, drp_di); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        r1 = 16'($urandom); r2 = 16'($urandom);
        mem[7'h0A] = r1; mem[7'h0B] = r2;
        issue(3'd1, 3'd4, 6'h33);
        wait_done(100, ok, dc, de);
        checks++; if (!ok || de !== 1'b0) begin errors++; $display("FAIL rstmid_after got ok=%0b err=%b exp ok=1 err=0", ok, de); end
        checks++; if (mem[7'h0A] !== {3'd4, r1[12:0]} || mem[7'h0B] !== {r2[15:6], 6'h33}) begin
            errors++; $display("FAIL rstmid_after_data got %h %h exp %h %h", mem[7'h0A], mem[7'h0B], {3'd4, r1[12:0]}, {r2[15:6], 6'h33}); end
    endtask

    task automatic test_random();
        bit ok; int dc; logic de;
        logic [2:0] sel, mux; logic [5:0] dly;
        logic [6:0] a1, a2; logic [15:0] v1, v2, w1, w2;
        logic ew [4]; logic [6:0] ea [4]; logic [15:0] ed [4];
        logic [24:0] got, exp;
        int exp_n; logic exp_err;
        for (int it = 0; it < 40; it++) begin
            sel = 3'($urandom_range(7, 0)); mux = 3'($urandom); dly = 6'($urandom);
            rand_lat = 1'($urandom_range(1, 0));
            drop_at = ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            a1 = 7'h00; a2 = 7'h00; w1 = '0; w2 = '0;
            if (sel <= 3'd5) begin
                a1 = base_tab[sel]; a2 = a1 + 7'd1;
                v1 = 16'($urandom); v2 = 16'($urandom);
                mem[a1] = v1; mem[a2] = v2;
                w1 = {mux, v1[12:0]};
                w2 = {v2[15:6], dly};
            end
            ew = '{1'b0, 1'b1, 1'b0, 1'b1};
            ea = '{a1, a1, a2, a2};
            ed = '{16'h0, w1, 16'h0, w2};
            if (sel > 3'd5)        begin exp_n = 0;           exp_err = 1'b1; end
            else if (drop_at >= 0) begin exp_n = drop_at + 1; exp_err = 1'b1; end
            else                   begin exp_n = 4;           exp_err = 1'b0; end
            issue(sel, mux, dly);
            wait_done(300, ok, dc, de);
            checks++; if (!ok || de !== exp_err) begin errors++; $display("FAIL rnd%0d_err got ok=%0b err=%b exp ok=1 err=%b", it, ok, de, exp_err); end
            checks++; if (acc_q.size() != exp_n) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", it, acc_q.size(), exp_n); end
            for (int k = 0; k < 4; k++) begin
                if (k < exp_n && k < acc_q.size()) begin
                    got = {acc_q[k].prst, acc_q[k].we, acc_q[k].addr, acc_q[k].we ? acc_q[k].di : 16'h0};
                    exp = {EXP_PRST, ew[k], ea[k], ed[k]};
                    checks++; if (got !== exp) begin errors++; $display("FAIL rnd%0d_acc%0d got %h exp %h", it, k, got, exp); end
                end
            end
            if (sel > 3'd5) begin
                checks++; if (dc - c0 != 2) begin errors++; $display("FAIL rnd%0d_badsel_latency got %0d exp 2", it, dc - c0); end
            end else if (drop_at >= 0) begin
                if (acc_q.size() > drop_at) begin
                    checks++; if (dc - acc_q[drop_at].cyc != TO) begin
                        errors++; $display("FAIL rnd%0d_to_latency got %0d exp %0d", it, dc - acc_q[drop_at].cyc, TO); end
                end
            end else begin
                checks++; if (mem[a1] !== w1 || mem[a2] !== w2) begin
                    errors++; $display("FAIL rnd%0d_mem got %h %h exp %h %h", it, mem[a1], mem[a2], w1, w2); end
                if (!rand_lat) begin
                    checks++; if (dc - c0 != 10 + EXTRA) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", it, dc - c0, 10 + EXTRA); end
                end
            end
        end
        drop_at = -1; rand_lat = 1'b0;
    endtask

`ifdef PLL_DRP_RST_EN
    task automatic test_lock();
        bit ok; int dc; logic de;
        pll_lock = 1'b0;
        issue(3'd3, 3'd2, 6'h0C);
        for (int i = 0; i < 30 && acc_q.size() < 4; i++) @(posedge clk);
        repeat (100) @(posedge clk);
        #1;
        checks++; if ({pll_rst, cfg_busy, cfg_done} !== 3'b010) begin
            errors++; $display("FAIL lock_wait got rst/busy/done %b exp 010", {pll_rst, cfg_busy, cfg_done}); end
        pll_lock = 1'b1;
        wait_done(20, ok, dc, de);
        checks++; if (!ok || de !== 1'b0) begin errors++; $display("FAIL lock_ok got ok=%0b err=%b exp ok=1 err=0", ok, de); end
        pll_lock = 1'b0;
        issue(3'd0, 3'd1, 6'h01);
        wait_done(LK + 200, ok, dc, de);
        checks++; if (!ok || de !== 1'b1) begin errors++; $display("FAIL lock_to got ok=%0b err=%b exp ok=1 err=1", ok, de); end
        checks++; if (dc - c0 != 10 + LK) begin errors++; $display("FAIL lock_to_latency got %0d exp %0d", dc - c0, 10 + LK); end
        pll_lock = 1'b1;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        test_reset();
        test_directed();
        test_outsel_range();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef PLL_DRP_RST_EN
        test_lock();
`endif
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL drp_bus_stability got %0d exp 0", stab_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
